// File: rtl/seq_mag_comp_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master drives the request; the comparator (slave) returns status and the result.
interface seq_mag_comp_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (
      output start, a, b, signed_mode,
      input  busy, done, gt, eq, lt
   );

   modport slave (
      input  start, a, b, signed_mode,
      output busy, done, gt, eq, lt
   );
endinterface

// File: rtl/seq_mag_comp.sv
// MSB-first bit-serial magnitude comparator with a three-state FSM.
// Handles unsigned and two's-complement operands, with optional early exit.
module seq_mag_comp #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   seq_mag_comp_if.slave  bus
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sgn;
   logic             r_dec_vld;
   logic             r_dec_gt;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic w_accept;
   logic w_bit_a;
   logic w_bit_b;
   logic w_diff;
   logic w_last;
   logic w_bit_gt;
   logic w_end;
   logic w_res_gt;
   logic w_res_eq;
   logic w_busy;
   logic w_done;

   assign w_accept = bus.start && (r_state != S_RUN);
   assign w_bit_a  = r_a[r_idx];
   assign w_bit_b  = r_b[r_idx];
   assign w_diff   = w_bit_a ^ w_bit_b;
   assign w_last   = (r_idx == '0);
   // The sign bit carries negative weight, so its decision is inverted
   assign w_bit_gt = (r_sgn && (r_idx == IDX_TOP)) ? ~w_bit_a : w_bit_a;
   assign w_end    = (EARLY_EXIT != 0) ? (w_diff || w_last) : w_last;
   // A latched earlier decision always wins over the current bit pair
   assign w_res_eq = !(r_dec_vld || w_diff);
   assign w_res_gt = r_dec_vld ? r_dec_gt : w_bit_gt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_end)     w_next = S_DONE;
         S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == S_RUN);
      w_done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_sgn     <= 1'b0;
         r_dec_vld <= 1'b0;
         r_dec_gt  <= 1'b0;
         r_gt      <= 1'b0;
         r_eq      <= 1'b0;
         r_lt      <= 1'b0;
      end else if (w_accept) begin
         r_idx     <= IDX_TOP;
         r_a       <= bus.a;
         r_b       <= bus.b;
         r_sgn     <= bus.signed_mode;
         r_dec_vld <= 1'b0;
         r_dec_gt  <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (w_end) begin
            r_gt <= !w_res_eq &&  w_res_gt;
            r_eq <=  w_res_eq;
            r_lt <= !w_res_eq && !w_res_gt;
         end else begin
            r_idx <= r_idx - 1'b1;
            // Only reachable without early exit: remember the first differing bit
            if (w_diff && !r_dec_vld) begin
               r_dec_vld <= 1'b1;
               r_dec_gt  <= w_bit_gt;
            end
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.gt   = r_gt;
   assign bus.eq   = r_eq;
   assign bus.lt   = r_lt;
endmodule
